trap_ctrl: RTL and testbench

- Trap and return sequencer for the machine-mode CSR file.
- On an exception/interrupt request or MRET, it takes ownership of the CSR file's single read port and single write port.
- Trap: reads mstatus and mtvec, then writes mepc, mcause, mtval and mstatus over several cycles, then issues a PC redirect.
- In idle it passes the pipeline's CSR read/write traffic straight through; `busy_o` stalls the pipeline while a sequence runs.

---
 rtl/trap_ctrl_if.sv | 35 +++
 rtl/trap_ctrl.sv | 166 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Bundles the pipeline, trap/MRET request, CSR-file and redirect signals of trap_ctrl.
// slave is the controller's view; master is the surrounding pipeline/CSR-file view.
interface trap_ctrl_if;
  logic        trap_req_i;
  logic [63:0] trap_pc_i;
  logic [63:0] trap_cause_i;
  logic [63:0] trap_tval_i;
  logic        mret_req_i;
  logic        pipe_we_i;
  logic [11:0] pipe_waddr_i;
  logic [63:0] pipe_wdata_i;
  logic [11:0] pipe_raddr_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [63:0] csr_wdata_o;
  logic [11:0] csr_raddr_o;
  logic [63:0] csr_rdata_i;
  logic        busy_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;

  modport slave (
    input  trap_req_i, trap_pc_i, trap_cause_i, trap_tval_i, mret_req_i,
    input  pipe_we_i, pipe_waddr_i, pipe_wdata_i, pipe_raddr_i, csr_rdata_i,
    output csr_we_o, csr_waddr_o, csr_wdata_o, csr_raddr_o,
    output busy_o, redirect_valid_o, redirect_pc_o
  );

  modport master (
    output trap_req_i, trap_pc_i, trap_cause_i, trap_tval_i, mret_req_i,
    output pipe_we_i, pipe_waddr_i, pipe_wdata_i, pipe_raddr_i, csr_rdata_i,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, csr_raddr_o,
    input  busy_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer owning the CSR read/write ports; trap redirects 7 cycles
// after accept, MRET 4; busy_o stalls the pipeline, requests while busy are ignored.
module trap_ctrl #(
  parameter logic [11:0] ADDR_MSTATUS = 12'h300,
  parameter logic [11:0] ADDR_MTVEC   = 12'h305,
  parameter logic [11:0] ADDR_MEPC    = 12'h341,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h342,
  parameter logic [11:0] ADDR_MTVAL   = 12'h343
) (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, T_RSTAT, T_RVEC, T_WEPC, T_WCAUSE, T_WTVAL, T_WSTAT, T_DONE,
    M_RSTAT, M_REPC, M_WSTAT, M_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] cause_q, cause_d;
  logic [63:0] tval_q, tval_d;
  logic [63:0] stat_q, stat_d;
  logic [63:0] vec_q, vec_d;
  logic [63:0] epc_q, epc_d;
  logic        busy_q, busy_d;
  logic        redir_vld_q, redir_vld_d;
  logic [63:0] redir_pc_q, redir_pc_d;

  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic [11:0] csr_raddr;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
    tval_d    = tval_q;
    stat_d    = stat_q;
    vec_d     = vec_q;
    epc_d     = epc_q;
    csr_we    = 1'b0;
    csr_waddr = 12'h000;
    csr_wdata = 64'h0;
    csr_raddr = bus.pipe_raddr_i;

    unique case (state_q)
      IDLE: begin
        if (bus.trap_req_i) begin
          pc_d    = bus.trap_pc_i;
          cause_d = bus.trap_cause_i;
          tval_d  = bus.trap_tval_i;
          state_d = T_RSTAT;
        end else if (bus.mret_req_i) begin
          state_d = M_RSTAT;
        end else begin
          csr_we    = bus.pipe_we_i;
          csr_waddr = bus.pipe_waddr_i;
          csr_wdata = bus.pipe_wdata_i;
        end
      end
      T_RSTAT: begin
        csr_raddr = ADDR_MSTATUS;
        stat_d    = bus.csr_rdata_i;
        state_d   = T_RVEC;
      end
      T_RVEC: begin
        csr_raddr = ADDR_MTVEC;
        vec_d     = bus.csr_rdata_i;
        state_d   = T_WEPC;
      end
      T_WEPC: begin
        csr_we    = 1'b1;
        csr_waddr = ADDR_MEPC;
        csr_wdata = pc_q;
        state_d   = T_WCAUSE;
      end
      T_WCAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = ADDR_MCAUSE;
        csr_wdata = cause_q;
        state_d   = T_WTVAL;
      end
      T_WTVAL: begin
        csr_we    = 1'b1;
        csr_waddr = ADDR_MTVAL;
        csr_wdata = tval_q;
        state_d   = T_WSTAT;
      end
      T_WSTAT: begin
        // Save interrupt enable into the previous-enable bit, then disable interrupts.
        csr_we       = 1'b1;
        csr_waddr    = ADDR_MSTATUS;
        csr_wdata    = stat_q;
        csr_wdata[3] = stat_q[0];
        csr_wdata[0] = 1'b0;
        state_d      = T_DONE;
      end
      T_DONE:  state_d = IDLE;
      M_RSTAT: begin
        csr_raddr = ADDR_MSTATUS;
        stat_d    = bus.csr_rdata_i;
        state_d   = M_REPC;
      end
      M_REPC: begin
        csr_raddr = ADDR_MEPC;
        epc_d     = bus.csr_rdata_i;
        state_d   = M_WSTAT;
      end
      M_WSTAT: begin
        // Restore interrupt enable from the previous-enable bit, which is then set.
        csr_we       = 1'b1;
        csr_waddr    = ADDR_MSTATUS;
        csr_wdata    = stat_q;
        csr_wdata[0] = stat_q[3];
        csr_wdata[3] = 1'b1;
        state_d      = M_DONE;
      end
      M_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    redir_vld_d = (state_d == T_DONE) || (state_d == M_DONE);
    redir_pc_d  = redir_pc_q;
    if (state_d == T_DONE) redir_pc_d = vec_q;
    if (state_d == M_DONE) redir_pc_d = epc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= 64'h0;
      cause_q     <= 64'h0;
      tval_q      <= 64'h0;
      stat_q      <= 64'h0;
      vec_q       <= 64'h0;
      epc_q       <= 64'h0;
      busy_q      <= 1'b0;
      redir_vld_q <= 1'b0;
      redir_pc_q  <= 64'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cause_q     <= cause_d;
      tval_q      <= tval_d;
      stat_q      <= stat_d;
      vec_q       <= vec_d;
      epc_q       <= epc_d;
      busy_q      <= busy_d;
      redir_vld_q <= redir_vld_d;
      redir_pc_q  <= redir_pc_d;
    end
  end

  assign bus.csr_we_o         = csr_we;
  assign bus.csr_waddr_o      = csr_waddr;
  assign bus.csr_wdata_o      = csr_wdata;
  assign bus.csr_raddr_o      = csr_raddr;
  assign bus.busy_o           = busy_q;
  assign bus.redirect_valid_o = redir_vld_q;
  assign bus.redirect_pc_o    = redir_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: passthrough, trap/MRET sequences, priority, back-to-back, async reset.
module tb_trap_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [63:0] m_status, m_tvec, m_epc;

  trap_ctrl_if bus();
  trap_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always_comb begin
    case (bus.csr_raddr_o)
      12'h300: bus.csr_rdata_i = m_status;
      12'h305: bus.csr_rdata_i = m_tvec;
      12'h341: bus.csr_rdata_i = m_epc;
      default: bus.csr_rdata_i = 64'h0;
    endcase
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.trap_req_i   = 1'b0;
    bus.trap_pc_i    = 64'h0;
    bus.trap_cause_i = 64'h0;
    bus.trap_tval_i  = 64'h0;
    bus.mret_req_i   = 1'b0;
    bus.pipe_we_i    = 1'b0;
    bus.pipe_waddr_i = 12'h0;
    bus.pipe_wdata_i = 64'h0;
    bus.pipe_raddr_i = 12'h0;
  endtask

  task automatic test_reset;
    idle_inputs();
    m_status = 64'h0; m_tvec = 64'h0; m_epc = 64'h0;
    #12;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.redirect_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rv: got %b expected 0", bus.redirect_valid_o); end
    checks++; if (bus.redirect_pc_o !== 64'h0) begin failures++; $display("FAIL reset_rpc: got %h expected 0", bus.redirect_pc_o); end
    checks++; if (bus.csr_we_o !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", bus.csr_we_o); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_passthrough;
    bus.pipe_we_i = 1'b1; bus.pipe_waddr_i = 12'h340; bus.pipe_wdata_i = 64'hDEAD; bus.pipe_raddr_i = 12'h305;
    #3;
    checks++; if (bus.csr_we_o !== 1'b1) begin failures++; $display("FAIL pass_we: got %b expected 1", bus.csr_we_o); end
    checks++; if (bus.csr_waddr_o !== 12'h340) begin failures++; $display("FAIL pass_waddr: got %h expected 340", bus.csr_waddr_o); end
    checks++; if (bus.csr_wdata_o !== 64'hDEAD) begin failures++; $display("FAIL pass_wdata: got %h expected dead", bus.csr_wdata_o); end
    checks++; if (bus.csr_raddr_o !== 12'h305) begin failures++; $display("FAIL pass_raddr: got %h expected 305", bus.csr_raddr_o); end
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL pass_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.redirect_valid_o !== 1'b0) begin failures++; $display("FAIL pass_rv: got %b expected 0", bus.redirect_valid_o); end
    tick();
    idle_inputs();
  endtask

  task automatic test_trap;
    logic        e_we[9], e_busy[9], e_rv[9];
    logic [11:0] e_waddr[9], e_raddr[9];
    logic [63:0] e_wdata[9];
    for (int c = 0; c < 9; c++) begin
      e_we[c] = 1'b0; e_busy[c] = (c >= 1 && c <= 7); e_rv[c] = (c == 7);
      e_waddr[c] = 12'h0; e_wdata[c] = 64'h0; e_raddr[c] = 12'h7FF;
    end
    e_raddr[1] = 12'h300; e_raddr[2] = 12'h305;
    e_we[3] = 1'b1; e_waddr[3] = 12'h341; e_wdata[3] = 64'h8000_0010;
    e_we[4] = 1'b1; e_waddr[4] = 12'h342; e_wdata[4] = 64'h2;
    e_we[5] = 1'b1; e_waddr[5] = 12'h343; e_wdata[5] = 64'h1234;
    e_we[6] = 1'b1; e_waddr[6] = 12'h300; e_wdata[6] = 64'h8;
    m_status = 64'h1; m_tvec = 64'h8000_0100;
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      bus.pipe_raddr_i = 12'h7FF;
      if (c == 0) begin
        bus.trap_req_i = 1'b1; bus.trap_pc_i = 64'h8000_0010;
        bus.trap_cause_i = 64'h2; bus.trap_tval_i = 64'h1234;
      end
      #3;
      checks++; if (bus.csr_we_o !== e_we[c]) begin failures++; $display("FAIL trap_we c%0d: got %b expected %b", c, bus.csr_we_o, e_we[c]); end
      checks++; if (bus.csr_waddr_o !== e_waddr[c]) begin failures++; $display("FAIL trap_waddr c%0d: got %h expected %h", c, bus.csr_waddr_o, e_waddr[c]); end
      checks++; if (bus.csr_wdata_o !== e_wdata[c]) begin failures++; $display("FAIL trap_wdata c%0d: got %h expected %h", c, bus.csr_wdata_o, e_wdata[c]); end
      checks++; if (bus.csr_raddr_o !== e_raddr[c]) begin failures++; $display("FAIL trap_raddr c%0d: got %h expected %h", c, bus.csr_raddr_o, e_raddr[c]); end
      checks++; if (bus.busy_o !== e_busy[c]) begin failures++; $display("FAIL trap_busy c%0d: got %b expected %b", c, bus.busy_o, e_busy[c]); end
      checks++; if (bus.redirect_valid_o !== e_rv[c]) begin failures++; $display("FAIL trap_rv c%0d: got %b expected %b", c, bus.redirect_valid_o, e_rv[c]); end
      if (c >= 7) begin
        checks++; if (bus.redirect_pc_o !== 64'h8000_0100) begin failures++; $display("FAIL trap_rpc c%0d: got %h expected 80000100", c, bus.redirect_pc_o); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_mret;
    m_status = 64'h8; m_epc = 64'h8000_0014;
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      bus.pipe_raddr_i = 12'h123;
      if (c == 0) bus.mret_req_i = 1'b1;
      #3;
      checks++; if (bus.busy_o !== (c >= 1 && c <= 4)) begin failures++; $display("FAIL mret_busy c%0d: got %b", c, bus.busy_o); end
      checks++; if (bus.redirect_valid_o !== (c == 4)) begin failures++; $display("FAIL mret_rv c%0d: got %b", c, bus.redirect_valid_o); end
      checks++; if (bus.csr_we_o !== (c == 3)) begin failures++; $display("FAIL mret_we c%0d: got %b", c, bus.csr_we_o); end
      if (c == 1) begin checks++; if (bus.csr_raddr_o !== 12'h300) begin failures++; $display("FAIL mret_raddr_stat: got %h expected 300", bus.csr_raddr_o); end end
      if (c == 2) begin checks++; if (bus.csr_raddr_o !== 12'h341) begin failures++; $display("FAIL mret_raddr_epc: got %h expected 341", bus.csr_raddr_o); end end
      if (c == 3) begin
        checks++; if (bus.csr_waddr_o !== 12'h300) begin failures++; $display("FAIL mret_waddr: got %h expected 300", bus.csr_waddr_o); end
        checks++; if (bus.csr_wdata_o !== 64'h9) begin failures++; $display("FAIL mret_wdata: got %h expected 9", bus.csr_wdata_o); end
        checks++; if (bus.csr_raddr_o !== 12'h123) begin failures++; $display("FAIL mret_raddr_pass: got %h expected 123", bus.csr_raddr_o); end
      end
      if (c == 4) begin checks++; if (bus.redirect_pc_o !== 64'h8000_0014) begin failures++; $display("FAIL mret_rpc: got %h expected 80000014", bus.redirect_pc_o); end end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_priority;
    int n_rv = 0, rv_cyc = -1, n_we = 0;
    m_status = 64'h0; m_tvec = 64'h8000_0200;
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      if (c == 0) begin
        bus.trap_req_i = 1'b1; bus.mret_req_i = 1'b1;
        bus.pipe_we_i = 1'b1; bus.pipe_waddr_i = 12'h340; bus.pipe_wdata_i = 64'hBEEF;
        bus.trap_pc_i = 64'h100; bus.trap_cause_i = 64'h8000_0000_0000_0007;
      end
      #3;
      if (c == 0) begin checks++; if (bus.csr_we_o !== 1'b0) begin failures++; $display("FAIL prio_drop_we: got %b expected 0", bus.csr_we_o); end end
      if (c == 4) begin
        checks++; if (bus.csr_waddr_o !== 12'h342) begin failures++; $display("FAIL prio_waddr: got %h expected 342", bus.csr_waddr_o); end
        checks++; if (bus.csr_wdata_o !== 64'h8000_0000_0000_0007) begin failures++; $display("FAIL prio_cause: got %h expected 8000000000000007", bus.csr_wdata_o); end
      end
      if (bus.csr_we_o === 1'b1) n_we++;
      if (bus.redirect_valid_o === 1'b1) begin n_rv++; rv_cyc = c; end
      tick();
    end
    checks++; if (n_we != 4) begin failures++; $display("FAIL prio_nwrites: got %0d expected 4", n_we); end
    checks++; if (n_rv != 1 || rv_cyc != 7) begin failures++; $display("FAIL prio_redirect: got n=%0d cyc=%0d expected n=1 cyc=7", n_rv, rv_cyc); end
    checks++; if (bus.redirect_pc_o !== 64'h8000_0200) begin failures++; $display("FAIL prio_rpc: got %h expected 80000200", bus.redirect_pc_o); end
  endtask

  task automatic test_mret_during_trap;
    int n_rv = 0, rv_cyc = -1;
    m_status = 64'h1; m_tvec = 64'h8000_0300; m_epc = 64'h8000_0500;
    for (int c = 0; c < 12; c++) begin
      idle_inputs();
      if (c == 0) begin bus.trap_req_i = 1'b1; bus.trap_pc_i = 64'h200; bus.trap_cause_i = 64'h5; bus.trap_tval_i = 64'hABC; end
      if (c == 2 || c == 5) bus.mret_req_i = 1'b1;
      #3;
      if (bus.redirect_valid_o === 1'b1) begin n_rv++; rv_cyc = c; end
      if (c == 8) begin checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL mdt_busy_c8: got %b expected 0", bus.busy_o); end end
      tick();
    end
    checks++; if (n_rv != 1 || rv_cyc != 7) begin failures++; $display("FAIL mdt_redirect: got n=%0d cyc=%0d expected n=1 cyc=7", n_rv, rv_cyc); end
    checks++; if (bus.redirect_pc_o !== 64'h8000_0300) begin failures++; $display("FAIL mdt_rpc: got %h expected 80000300", bus.redirect_pc_o); end
  endtask

  task automatic test_back_to_back;
    m_status = 64'h1; m_tvec = 64'h8000_0600; m_epc = 64'h8000_0400;
    for (int c = 0; c < 14; c++) begin
      idle_inputs();
      if (c == 0) begin bus.trap_req_i = 1'b1; bus.trap_pc_i = 64'h300; end
      if (c == 8) bus.mret_req_i = 1'b1;
      #3;
      if (c == 7) begin checks++; if (bus.redirect_pc_o !== 64'h8000_0600 || bus.redirect_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_trap_rd: got v=%b pc=%h expected v=1 pc=80000600", bus.redirect_valid_o, bus.redirect_pc_o); end end
      if (c == 9) begin checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL b2b_busy_c9: got %b expected 1", bus.busy_o); end end
      if (c == 12) begin checks++; if (bus.redirect_pc_o !== 64'h8000_0400 || bus.redirect_valid_o !== 1'b1) begin failures++; $display("FAIL b2b_mret_rd: got v=%b pc=%h expected v=1 pc=80000400", bus.redirect_valid_o, bus.redirect_pc_o); end end
      if (c == 13) begin checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL b2b_busy_c13: got %b expected 0", bus.busy_o); end end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    int n_we = 0, n_rv = 0;
    m_status = 64'h1; m_tvec = 64'h8000_0700;
    for (int c = 0; c < 5; c++) begin
      idle_inputs();
      bus.pipe_raddr_i = 12'h0AB;
      if (c == 0) begin bus.trap_req_i = 1'b1; bus.trap_pc_i = 64'h8000_0020; bus.trap_cause_i = 64'h3; end
      #3;
      if (c == 3) begin checks++; if (bus.csr_we_o !== 1'b1 || bus.csr_waddr_o !== 12'h341) begin failures++; $display("FAIL rmid_mepc: got we=%b addr=%h expected we=1 addr=341", bus.csr_we_o, bus.csr_waddr_o); end end
      if (c == 4) begin checks++; if (bus.csr_waddr_o !== 12'h342) begin failures++; $display("FAIL rmid_wcause: got %h expected 342", bus.csr_waddr_o); end end
      if (c < 4) tick();
    end
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b expected 0", bus.busy_o); end
    checks++; if (bus.csr_we_o !== 1'b0) begin failures++; $display("FAIL rmid_we: got %b expected 0", bus.csr_we_o); end
    checks++; if (bus.redirect_pc_o !== 64'h0) begin failures++; $display("FAIL rmid_rpc: got %h expected 0", bus.redirect_pc_o); end
    checks++; if (bus.csr_raddr_o !== 12'h0AB) begin failures++; $display("FAIL rmid_raddr: got %h expected 0ab", bus.csr_raddr_o); end
    #1 rst = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      #3;
      if (bus.csr_we_o === 1'b1) n_we++;
      if (bus.redirect_valid_o === 1'b1 || bus.busy_o === 1'b1) n_rv++;
      tick();
    end
    checks++; if (n_we != 0) begin failures++; $display("FAIL rmid_post_writes: got %0d expected 0", n_we); end
    checks++; if (n_rv != 0) begin failures++; $display("FAIL rmid_post_activity: got %0d expected 0", n_rv); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_trap();
    test_mret();
    test_priority();
    test_mret_during_trap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
